// File: rtl/tmp_pkg.sv
// tmp_pkg: shared temperature-sensor types and defaults (decimator FSM states, window/settle sizes)
package tmp_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} tmp_state_e;
    localparam int TMP_OSR_LOG2 = 8;
    localparam int TMP_SETTLE_N = 4;
endpackage

// File: rtl/tmp_decim_acc.sv
// tmp_decim_acc: strobe and ones counters over a 2^OSR_LOG2 window with window-done pulse and result
module tmp_decim_acc
    import tmp_pkg::*;
#(
    parameter int OSR_LOG2 = TMP_OSR_LOG2,
    localparam int CW = OSR_LOG2 + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          stb,
    input  logic          bit_in,
    output logic          done,
    output logic [CW-1:0] result
);
    logic [OSR_LOG2-1:0] cnt;
    logic [CW-1:0]       ones;

    assign result = ones + CW'(bit_in);
    assign done   = stb && (cnt == '1);

    // count strobes and ones; both restart on the window's last strobe so windows abut
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt  <= '0;
            ones <= '0;
        end else if (stb) begin
            cnt  <= cnt + 1'b1;
            ones <= done ? '0 : result;
        end
    end
endmodule

// File: rtl/tmp_decim.sv
// tmp_decim: ones-count decimator with settle prefix and single-entry valid/ready output
// Define TMP_DECIM_DROPOLD_EN to keep the newest result on overrun (default keeps the oldest).
module tmp_decim
    import tmp_pkg::*;
#(
    parameter int OSR_LOG2 = TMP_OSR_LOG2,
    parameter int SETTLE_N = TMP_SETTLE_N,
    localparam int CW = OSR_LOG2 + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          bit_stb,
    input  logic          bit_in,
    input  logic          out_ready,
    output logic [CW-1:0] code,
    output logic          code_valid,
    output logic          overrun,
    output logic          busy
);
    localparam int SW = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;

    tmp_state_e    state, nxt;
    logic [SW-1:0] scnt;
    logic          done;
    logic [CW-1:0] result;
    logic          xfer;

    assign xfer = code_valid && out_ready;
    assign busy = (state != IDLE);

    tmp_decim_acc #(.OSR_LOG2(OSR_LOG2)) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (state != ACCUM || !enable),
        .stb    (bit_stb && enable && state == ACCUM),
        .bit_in (bit_in),
        .done   (done),
        .result (result)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // next state: enable low always aborts; settle ends on the SETTLE_N-th strobe
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (enable) nxt = (SETTLE_N == 0) ? ACCUM : SETTLE;
            SETTLE:  nxt = !enable ? IDLE : (bit_stb && scnt == SW'(SETTLE_N - 1)) ? ACCUM : SETTLE;
            ACCUM:   if (!enable) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // settle strobe counter, held at zero outside SETTLE
    always_ff @(posedge clk) begin
        if (!reset || state != SETTLE) scnt <= '0;
        else if (enable && bit_stb)    scnt <= scnt + 1'b1;
    end

    // output register: load on window done, release on handshake, flag lost results
    always_ff @(posedge clk) begin
        if (!reset) begin
            code       <= '0;
            code_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!code_valid || xfer) begin
                code       <= result;
                code_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
`ifdef TMP_DECIM_DROPOLD_EN
                code    <= result;
`else
                code    <= code;
`endif
            end
        end else if (xfer) begin
            code_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tmp_decim.sv
// tb_tmp_decim: directed self-checking bench for tmp_decim with OSR_LOG2=4, SETTLE_N=4
module tb_tmp_decim;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       bit_stb = 1'b0;
    logic       bit_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] code;
    logic       code_valid;
    logic       overrun;
    logic       busy;
    int         tests = 0;
    int         fails = 0;

    tmp_decim #(.OSR_LOG2(4), .SETTLE_N(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_stb    (bit_stb),
        .bit_in     (bit_in),
        .out_ready  (out_ready),
        .code       (code),
        .code_valid (code_valid),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic b);
        bit_stb = s;
        bit_in  = b;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_code", 32'(code), 0);
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);

        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        cyc(0, 0);
        chk("start_busy", 32'(busy), 1);
        for (int i = 0; i < 19; i++) cyc(1, 1);
        chk("ones_pre_valid", 32'(code_valid), 0);
        cyc(1, 1);
        chk("ones_code", 32'(code), 16);
        chk("ones_valid", 32'(code_valid), 1);
        cyc(0, 0);
        chk("ones_valid_drop", 32'(code_valid), 0);

        for (int i = 0; i < 16; i++) cyc(1, (i % 2) == 0);
        chk("alt_code", 32'(code), 8);
        chk("alt_valid", 32'(code_valid), 1);
        for (int i = 0; i < 15; i++) cyc(1, 0);
        chk("zero_pre_valid", 32'(code_valid), 0);
        cyc(1, 0);
        chk("zero_code", 32'(code), 0);
        chk("zero_valid", 32'(code_valid), 1);
        cyc(0, 0);
        chk("zero_valid_drop", 32'(code_valid), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc(1, 0);
        chk("bp_first_code", 32'(code), 0);
        chk("bp_first_overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) cyc(1, 1);
        chk("bp_overrun", 32'(overrun), 1);
        chk("bp_valid", 32'(code_valid), 1);
`ifdef TMP_DECIM_DROPOLD_EN
        chk("bp_code", 32'(code), 16);
`else
        chk("bp_code", 32'(code), 0);
`endif

        for (int i = 0; i < 5; i++) cyc(1, 1);
        reset = 1'b0;
        cyc(0, 0);
        chk("mid_rst_code", 32'(code), 0);
        chk("mid_rst_valid", 32'(code_valid), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        reset = 1'b1;
        cyc(0, 0);
        chk("restart_busy", 32'(busy), 1);

        for (int i = 0; i < 20; i++) cyc(1, 1);
        chk("same_first_code", 32'(code), 16);
        chk("same_first_valid", 32'(code_valid), 1);
        for (int i = 0; i < 15; i++) cyc(1, 0);
        out_ready = 1'b1;
        cyc(1, 0);
        chk("same_code", 32'(code), 0);
        chk("same_valid", 32'(code_valid), 1);
        chk("same_overrun", 32'(overrun), 0);
        cyc(0, 0);
        chk("same_valid_drop", 32'(code_valid), 0);

        for (int i = 0; i < 10; i++) cyc(1, 1);
        enable = 1'b0;
        cyc(1, 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(code_valid), 0);
        cyc(1, 1);
        chk("abort_idle_valid", 32'(code_valid), 0);
        enable = 1'b1;
        cyc(0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1);
        for (int i = 0; i < 12; i++) cyc(1, 0);
        chk("fresh_pre_valid", 32'(code_valid), 0);
        cyc(1, 0);
        chk("fresh_code", 32'(code), 3);
        chk("fresh_valid", 32'(code_valid), 1);
        cyc(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
